data_loader: RTL

DATA_LOADER -- requirements
Module: data_loader

---
 rtl/data_loader_pkg.sv | 10 +
 rtl/data_loader_start_edge_detect.sv | 19 +
 rtl/data_loader.sv | 71 +++++++
 3 files changed

// File: rtl/data_loader_pkg.sv
// data_loader_pkg: shared FSM state encoding and default widths for the UART-to-memory loader.
package data_loader_pkg;
  localparam int ADDR_W_DEF = 18;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RECEIVING = 2'b01,
    DONE      = 2'b10
  } state_t;
endpackage

// File: rtl/data_loader_start_edge_detect.sv
// start_edge_detect: two-flop sampling of the active-low start button with falling-edge detection.
module start_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic fall
);
  logic a, b;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= 1'b1;
      b <= 1'b1;
    end else begin
      a <= start;
      b <= a;
    end
  end
  assign fall = ~a & b;
endmodule

// File: rtl/data_loader.sv
// data_loader: writes UART bytes to consecutive memory addresses from 0 up to a latched end address.
module data_loader
  import data_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              Rx_tick_from_rx,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_err,
  input  logic [ADDR_W-1:0] end_add,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              wen,
  output logic              busy,
  output logic              fin,
  output logic [7:0]        err_cnt
);
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, end_lat;
  logic fall, take, last_wr;
  start_edge_detect u_sed (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .fall  (fall)
  );
  assign take    = (state == RECEIVING) && Rx_tick_from_rx;
  assign last_wr = take && (cnt == end_lat);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  always_comb begin
    state_n = IDLE;
    state_n = (state == IDLE)      ? (fall ? RECEIVING : IDLE) :
              (state == RECEIVING) ? (last_wr ? DONE : RECEIVING) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr    <= '0;
      wdata   <= '0;
      wen     <= 1'b0;
      busy    <= 1'b0;
      fin     <= 1'b0;
      err_cnt <= '0;
      cnt     <= '0;
      end_lat <= '0;
    end else begin
      wen  <= take;
      busy <= (state_n != IDLE);
      if (state == IDLE && fall) begin
        end_lat <= end_add;
        cnt     <= '0;
        err_cnt <= '0;
        fin     <= 1'b0;
      end
      if (take) begin
        addr  <= cnt;
        wdata <= rx_data;
        // hold the counter on the final write so an all-ones end address never wraps
        if (!last_wr) cnt <= cnt + ADDR_W'(1);
        if (rx_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
      if (state == DONE) fin <= 1'b1;
    end
  end
endmodule
